// File: rtl/disp_pkg.sv
// disp_pkg: shared constants for the multiplexed seven-segment scanner.
//   SEG_0..SEG_F : active-low hex glyphs, bit order {g,f,e,d,c,b,a}
//   SEG_OFF      : all segments dark
//   MAX_DIGITS   : largest supported digit count
package disp_pkg;

    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NIB_W      = 4;

    localparam logic [SEG_W-1:0] SEG_0   = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1   = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2   = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3   = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4   = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5   = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6   = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7   = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8   = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9   = 7'h10;
    localparam logic [SEG_W-1:0] SEG_A   = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B   = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C   = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D   = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E   = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F   = 7'h0E;
    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: combinational hex nibble to active-low seven-segment glyph.
//   nibble_i : 4-bit value 0..F
//   glyph_o  : segments {g,f,e,d,c,b,a}, 0 = lit
module seg_hex_decode
    import disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    output logic [SEG_W-1:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_OFF;
        unique case (nibble_i)
            4'h0: glyph_o = SEG_0;
            4'h1: glyph_o = SEG_1;
            4'h2: glyph_o = SEG_2;
            4'h3: glyph_o = SEG_3;
            4'h4: glyph_o = SEG_4;
            4'h5: glyph_o = SEG_5;
            4'h6: glyph_o = SEG_6;
            4'h7: glyph_o = SEG_7;
            4'h8: glyph_o = SEG_8;
            4'h9: glyph_o = SEG_9;
            4'hA: glyph_o = SEG_A;
            4'hB: glyph_o = SEG_B;
            4'hC: glyph_o = SEG_C;
            4'hD: glyph_o = SEG_D;
            4'hE: glyph_o = SEG_E;
            4'hF: glyph_o = SEG_F;
            default: glyph_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed seven-segment display scanner.
//   clk, rstn   : clock, asynchronous active-low reset
//   disp_data   : 4*DIGITS hex nibbles, digit 0 in [3:0]
//   dp_in       : per-digit decimal point request (1 = lit)
//   digit_en    : per-digit enable (0 = dark in its slot)
//   blank       : 1 = all digits dark, scanning continues
//   seg, dp, AN : registered active-low segment / dp / anode drives
//   frame_start : one-cycle pulse after the edge that selects digit 0
// Optional: define DISP_SCAN_LZ_BLANK_EN for leading-zero suppression.
module disp_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIGITS   = 8,
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [NIB_W*DIGITS-1:0] disp_data,
    input  logic [DIGITS-1:0]       dp_in,
    input  logic [DIGITS-1:0]       digit_en,
    input  logic                    blank,
    output logic [SEG_W-1:0]        seg,
    output logic                    dp,
    output logic [DIGITS-1:0]       AN,
    output logic                    frame_start
);

    localparam int unsigned CNT_W  = $clog2(SCAN_DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned DATA_W = NIB_W * DIGITS;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] snap_data_q, snap_data_d;
    logic [DIGITS-1:0] snap_dp_q, snap_dp_d;
    logic [DIGITS-1:0] snap_en_q, snap_en_d;

    logic              tick_c;
    logic              wrap_c;
    logic [DIGITS-1:0] sup_c;
    logic [NIB_W-1:0]  sel_nib_c;
    logic              sel_en_c;
    logic              sel_dp_c;
    logic              sel_sup_c;
    logic              lit_c;
    logic [SEG_W-1:0]  glyph_c;

    logic [SEG_W-1:0]  seg_d;
    logic              dp_d;
    logic [DIGITS-1:0] an_d;

    assign tick_c = (cnt_q == CNT_LAST);
    assign wrap_c = tick_c && (idx_q == IDX_LAST);

    // Prescaler, digit index and per-frame snapshot.
    always_comb begin
        cnt_d       = tick_c ? '0 : cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        snap_data_d = snap_data_q;
        snap_dp_d   = snap_dp_q;
        snap_en_d   = snap_en_q;
        if (tick_c) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
        if (wrap_c) begin
            snap_data_d = disp_data;
            snap_dp_d   = dp_in;
            snap_en_d   = digit_en;
        end
    end

    // Leading-zero suppression walks down from the top digit; the first
    // enabled digit with a non-zero nibble or a dp request ends it.
`ifdef DISP_SCAN_LZ_BLANK_EN
    always_comb begin
        logic leading;
        sup_c   = '0;
        leading = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            if (snap_en_d[i]) begin
                if ((snap_data_d[NIB_W*i +: NIB_W] != '0) || snap_dp_d[i]) begin
                    leading = 1'b0;
                end
            end
            sup_c[i] = leading;
        end
    end
`else
    assign sup_c = '0;
`endif

    // Outputs decode from the next index and next snapshot, so the wrap edge
    // sees live inputs and blank takes effect on every edge.
    always_comb begin
        sel_nib_c = '0;
        sel_en_c  = 1'b0;
        sel_dp_c  = 1'b0;
        sel_sup_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_d == IDX_W'(i)) begin
                sel_nib_c = snap_data_d[NIB_W*i +: NIB_W];
                sel_en_c  = snap_en_d[i];
                sel_dp_c  = snap_dp_d[i];
                sel_sup_c = sup_c[i];
            end
        end
    end

    seg_hex_decode u_dec (
        .nibble_i (sel_nib_c),
        .glyph_o  (glyph_c)
    );

    assign lit_c = sel_en_c && !blank && !sel_sup_c;

    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (lit_c) begin
            seg_d = glyph_c;
            dp_d  = ~sel_dp_c;
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_d == IDX_W'(i)) begin
                    an_d[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            idx_q       <= IDX_LAST;
            snap_data_q <= '0;
            snap_dp_q   <= '0;
            snap_en_q   <= '0;
            AN          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            snap_data_q <= snap_data_d;
            snap_dp_q   <= snap_dp_d;
            snap_en_q   <= snap_en_d;
            AN          <= an_d;
            seg         <= seg_d;
            dp          <= dp_d;
            frame_start <= wrap_c;
        end
    end

endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: table vectors, hand-written corner sequences and a randomized
// run checked every cycle against an arithmetic reference model.
module tb_disp_scan;

    localparam int SD = 4;
    localparam int DG = 4;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] disp_data = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic        blank = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  AN;
    logic        frame_start;

    int checks = 0;
    int failures = 0;

    disp_scan #(.DIGITS(DG), .SCAN_DIV(SD)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .disp_data   (disp_data),
        .dp_in       (dp_in),
        .digit_en    (digit_en),
        .blank       (blank),
        .seg         (seg),
        .dp          (dp),
        .AN          (AN),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Edge n after release: ticks = n/SD, selected digit = (ticks-1) mod DG.
    function automatic logic [6:0] glyph(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'h3F; 4'h1: on = 7'h06; 4'h2: on = 7'h5B; 4'h3: on = 7'h4F;
            4'h4: on = 7'h66; 4'h5: on = 7'h6D; 4'h6: on = 7'h7D; 4'h7: on = 7'h07;
            4'h8: on = 7'h7F; 4'h9: on = 7'h6F; 4'hA: on = 7'h77; 4'hB: on = 7'h7C;
            4'hC: on = 7'h39; 4'hD: on = 7'h5E; 4'hE: on = 7'h79; default: on = 7'h71;
        endcase
        return ~on;
    endfunction

    function automatic logic [3:0] nib_of(input logic [15:0] d, input int i);
        logic [15:0] t;
        t = d >> (4 * i);
        return t[3:0];
    endfunction

    function automatic logic is_wrap(input int n);
        return (n > 0) && (n % SD == 0) && (((n / SD) - 1) % DG == 0);
    endfunction

    // Returns {AN, seg, dp}.
    function automatic logic [11:0] expect_out(input int n, input logic [15:0] d,
                                               input logic [3:0] p, input logic [3:0] e,
                                               input logic b);
        int ticks, k, stop;
        logic sup, lit;
        logic [3:0] nib;
        ticks = n / SD;
        if (ticks == 0) return {4'hF, 7'h7F, 1'b1};
        k    = (ticks - 1) % DG;
        nib  = nib_of(d, k);
        sup  = 1'b0;
`ifdef DISP_SCAN_LZ_BLANK_EN
        stop = 0;
        for (int i = 1; i < DG; i++)
            if (e[i] && (nib_of(d, i) != 4'h0 || p[i])) stop = i;
        sup = (k > stop) && (nib == 4'h0);
`else
        stop = 0;
`endif
        lit = e[k] && !b && !sup;
        if (!lit) return {4'hF, 7'h7F, 1'b1};
        return {~(4'b0001 << k), glyph(nib), ~p[k]};
    endfunction

    int          m_n;
    logic [15:0] m_sd;
    logic [3:0]  m_sp, m_se;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_n   <= 0;
            m_sd  <= '0;
            m_sp  <= '0;
            m_se  <= '0;
            e_an  <= 4'hF;
            e_seg <= 7'h7F;
            e_dp  <= 1'b1;
            e_fs  <= 1'b0;
        end else begin
            m_n <= m_n + 1;
            if (is_wrap(m_n + 1)) begin
                m_sd <= disp_data;
                m_sp <= dp_in;
                m_se <= digit_en;
            end
            {e_an, e_seg, e_dp} <= expect_out(m_n + 1,
                                              is_wrap(m_n + 1) ? disp_data : m_sd,
                                              is_wrap(m_n + 1) ? dp_in : m_sp,
                                              is_wrap(m_n + 1) ? digit_en : m_se,
                                              blank);
            e_fs <= is_wrap(m_n + 1);
        end
    end

    // ---------------- check helpers ----------------
    task automatic step();
        @(negedge clk);
        checks++;
        if ({AN, seg, dp, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            failures++;
            $display("FAIL model_cmp t=%0t got AN=%h seg=%h dp=%b fs=%b want AN=%h seg=%h dp=%b fs=%b",
                     $time, AN, seg, dp, frame_start, e_an, e_seg, e_dp, e_fs);
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic restart(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        rstn      = 1'b0;
        disp_data = d;
        dp_in     = p;
        digit_en  = e;
        blank     = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0]      d;
        logic [3:0]       p;
        logic [3:0]       e;
        logic [3:0][3:0]  an;
        logic [3:0][6:0]  sg;
        logic [3:0]       dpo;
    } vec_t;

    vec_t vt[5];

    initial begin
        int c;
        bit found;

        vt[0] = '{d:16'h12AF, p:4'h0, e:4'hF, an:16'h7BDE,
                  sg:{7'h79, 7'h24, 7'h08, 7'h0E}, dpo:4'hF};
        vt[1] = '{d:16'h4321, p:4'h1, e:4'h5, an:16'hFBFE,
                  sg:{7'h7F, 7'h30, 7'h7F, 7'h79}, dpo:4'hE};
`ifdef DISP_SCAN_LZ_BLANK_EN
        vt[2] = '{d:16'h0030, p:4'h0, e:4'hF, an:16'hFFDE,
                  sg:{7'h7F, 7'h7F, 7'h30, 7'h40}, dpo:4'hF};
        vt[3] = '{d:16'h0030, p:4'h4, e:4'hF, an:16'hFBDE,
                  sg:{7'h7F, 7'h40, 7'h30, 7'h40}, dpo:4'hB};
`else
        vt[2] = '{d:16'h0030, p:4'h0, e:4'hF, an:16'h7BDE,
                  sg:{7'h40, 7'h40, 7'h30, 7'h40}, dpo:4'hF};
        vt[3] = '{d:16'h0030, p:4'h4, e:4'hF, an:16'h7BDE,
                  sg:{7'h40, 7'h40, 7'h30, 7'h40}, dpo:4'hB};
`endif
        vt[4] = '{d:16'h8888, p:4'hF, e:4'h0, an:16'hFFFF,
                  sg:{7'h7F, 7'h7F, 7'h7F, 7'h7F}, dpo:4'hF};

        step();
        check("reset_an",  32'(AN), 32'hF);
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_dp",  32'(dp), 32'h1);
        check("reset_fs",  32'(frame_start), 32'h0);

        for (int v = 0; v < 5; v++) begin
            restart(vt[v].d, vt[v].p, vt[v].e);
            for (int s = 0; s < DG; s++) begin
                repeat (SD) step();
                check($sformatf("vec%0d_an%0d", v, s), 32'(AN), 32'(vt[v].an[s]));
                check($sformatf("vec%0d_seg%0d", v, s), 32'(seg), 32'(vt[v].sg[s]));
                check($sformatf("vec%0d_dp%0d", v, s), 32'(dp), 32'(vt[v].dpo[s]));
            end
        end

        // Tearing: new data mid-frame only shows from the next frame.
        restart(16'h1234, 4'h0, 4'hF);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (AN == 4'hB) found = 1'b1;
        end
        check("tear_find_digit2", 32'(found), 32'h1);
        disp_data = 16'h5678;
        check("tear_d2_seg", 32'(seg), 32'h24);
        repeat (SD) step();
        check("tear_d3_an", 32'(AN), 32'h7);
        check("tear_d3_seg", 32'(seg), 32'h79);
        repeat (SD) step();
        check("tear_new_an", 32'(AN), 32'hE);
        check("tear_new_seg", 32'(seg), 32'h00);
        check("tear_new_fs", 32'(frame_start), 32'h1);

        // Blank mid-slot for 3 cycles; frame period unchanged.
        c = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (frame_start) found = 1'b1;
        end
        check("blank_find_fs", 32'(found), 32'h1);
        for (c = 1; c <= 16; c++) begin
            step();
            if (c == 6)  check("blank_forced", 32'(AN), 32'hF);
            if (c == 9)  check("blank_release", 32'(AN), 32'hB);
            if (c == 15) check("blank_no_early_fs", 32'(frame_start), 32'h0);
            if (c == 16) check("blank_fs_period", 32'(frame_start), 32'h1);
            if (c == 5) blank = 1'b1;
            if (c == 8) blank = 1'b0;
        end

        // Mid-frame reset pulse of 2 cycles.
        repeat (6) step();
        #2 rstn = 1'b0;
        #1;
        check("rst_async_an", 32'(AN), 32'hF);
        check("rst_async_seg", 32'(seg), 32'h7F);
        check("rst_async_dp", 32'(dp), 32'h1);
        check("rst_async_fs", 32'(frame_start), 32'h0);
        repeat (2) step();
        rstn = 1'b1;
        c = 0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            c++;
            if (AN != 4'hF) found = 1'b1;
        end
        check("rst_first_lit_delay", 32'(c), 32'(SD));
        check("rst_first_lit_an", 32'(AN), 32'hE);
        check("rst_first_lit_fs", 32'(frame_start), 32'h1);

        // Randomized run against the model.
        for (int i = 0; i < 1500; i++) begin
            step();
            if ($urandom_range(0, 7) == 0) begin
                disp_data = 16'($urandom);
                if ($urandom_range(0, 1) == 1) disp_data[15:8] = 8'h00;
                if ($urandom_range(0, 3) == 0) disp_data[7:4] = 4'h0;
            end
            if ($urandom_range(0, 7) == 0) dp_in = 4'($urandom);
            if ($urandom_range(0, 7) == 0) digit_en = 4'($urandom);
            if ($urandom_range(0, 9) == 0) blank = ~blank;
            if ($urandom_range(0, 199) == 0) begin
                rstn = 1'b0;
                repeat ($urandom_range(1, 2)) step();
                rstn = 1'b1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
